clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_gen.sv | 104 ++++++++++
 tb/tb_clk_div_gen.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// Integer clock divider with bypass, glitch-free ratio switching at period
// boundaries. Optional CLK_DIV_ODD_DUTY_EN gives 50% duty for odd ratios.
module clk_div_gen #(
   parameter int WIDTH = 8
) (
   input  logic             i_ref_clk,
   input  logic             i_rst_n,
   input  logic             i_clk_en,
   input  logic [WIDTH-1:0] i_div_ratio,
   output logic             o_div_clk,
   output logic             o_div_tick,
   output logic [WIDTH-1:0] o_active_ratio
);

   typedef enum logic {
      BYPASS,
      RUN
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_nx;
   logic [WIDTH-1:0] half;
   logic             div_q;
   logic             req_ok;
   logic             wrap;
   logic             run_clk;

   // a request is honoured only with enable high and a real ratio (>=2)
   assign req_ok   = i_clk_en && (i_div_ratio >= WIDTH'(2));
   assign wrap     = (count == (o_active_ratio - WIDTH'(1)));
   assign count_nx = count + WIDTH'(1);
   // high phase length: ceil(N/2), computed without an extra carry bit
   assign half     = o_active_ratio - (o_active_ratio >> 1);

   // state, period counter and registered outputs
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= BYPASS;
         count          <= '0;
         o_active_ratio <= '0;
         o_div_tick     <= 1'b0;
         div_q          <= 1'b0;
      end else begin
         unique case (state)
            BYPASS: begin
               if (req_ok) begin
                  state          <= RUN;
                  o_active_ratio <= i_div_ratio;
                  count          <= '0;
                  o_div_tick     <= 1'b1;
                  div_q          <= 1'b1;
               end else begin
                  count          <= '0;
                  o_active_ratio <= '0;
                  o_div_tick     <= 1'b0;
                  div_q          <= 1'b0;
               end
            end
            RUN: begin
               if (!wrap) begin
                  count      <= count_nx;
                  o_div_tick <= 1'b0;
                  div_q      <= (count_nx < half);
               end else if (req_ok) begin
                  o_active_ratio <= i_div_ratio;
                  count          <= '0;
                  o_div_tick     <= 1'b1;
                  div_q          <= 1'b1;
               end else begin
                  state          <= BYPASS;
                  o_active_ratio <= '0;
                  count          <= '0;
                  o_div_tick     <= 1'b0;
                  div_q          <= 1'b0;
               end
            end
            default: begin
               state <= BYPASS;
            end
         endcase
      end
   end

`ifdef CLK_DIV_ODD_DUTY_EN
   logic div_n;

   // half-cycle delayed copy; ANDing trims half a ref period off the high
   always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_n <= 1'b0;
      end else begin
         div_n <= div_q;
      end
   end

   assign run_clk = o_active_ratio[0] ? (div_q & div_n) : div_q;
`else
   assign run_clk = div_q;
`endif

   assign o_div_clk = (state == RUN) ? run_clk : i_ref_clk;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: a period-level model queues the
// expected per-cycle outputs for each divided period as it starts.
module tb_clk_div_gen;

   logic       ref_clk;
   logic       rst_n;
   logic       clk_en;
   logic [7:0] div_ratio;
   logic       div_clk;
   logic       div_tick;
   logic [7:0] active_ratio;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic       hi_p;
      logic       hi_n;
      logic       tick;
      logic [7:0] ratio;
   } ent_t;

   ent_t q[$];

   wire [9:0] obs = {div_clk, div_tick, active_ratio};

   clk_div_gen #(.WIDTH(8)) dut (
      .i_ref_clk     (ref_clk),
      .i_rst_n       (rst_n),
      .i_clk_en      (clk_en),
      .i_div_ratio   (div_ratio),
      .o_div_clk     (div_clk),
      .o_div_tick    (div_tick),
      .o_active_ratio(active_ratio)
   );

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   // model: a period of N entries is queued when the previous one ends
   always @(posedge ref_clk) begin
      int n;
      ent_t e;
      if (q.size() > 0) void'(q.pop_front());
      if (!rst_n) begin
         q.delete();
      end else if (q.size() == 0 && clk_en && div_ratio >= 2) begin
         n = int'(div_ratio);
         for (int k = 0; k < n; k++) begin
            e.hi_n  = (k < (n + 1) / 2);
            e.hi_p  = e.hi_n;
`ifdef CLK_DIV_ODD_DUTY_EN
            if (n % 2 == 1) e.hi_p = (k >= 1) && (k < (n + 1) / 2);
`endif
            e.tick  = (k == 0);
            e.ratio = div_ratio;
            q.push_back(e);
         end
      end
   end

   function automatic logic [9:0] exp_now();
      if (q.size() == 0) return {ref_clk, 1'b0, 8'd0};
      return {ref_clk ? q[0].hi_p : q[0].hi_n, q[0].tick, q[0].ratio};
   endfunction

   function automatic int cur_pos();
      if (q.size() == 0) return -1;
      return int'(q[0].ratio) - q.size();
   endfunction

   task automatic test_reset();
      logic [9:0] e;
      rst_n = 1'b0;
      clk_en = 1'b1;
      div_ratio = 8'd4;
      for (int i = 0; i < 3; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_hi: got %b expected %b", obs, e);
         end
         @(negedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_lo: got %b expected %b", obs, e);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_ratio4();
      logic [9:0] e;
      int ticks = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL ratio4_hi cyc %0d: got %b expected %b", i, obs, e);
         end
         ticks += int'(div_tick);
         @(negedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL ratio4_lo cyc %0d: got %b expected %b", i, obs, e);
         end
      end
      n_chk++;
      if (ticks !== 3) begin
         n_fail++;
         $display("FAIL ratio4_ticks: got %0d expected 3", ticks);
      end
   endtask

   task automatic test_ratio5();
      logic [9:0] e;
      div_ratio = 8'd5;
      for (int i = 0; i < 20; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL ratio5_hi cyc %0d: got %b expected %b", i, obs, e);
         end
         @(negedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL ratio5_lo cyc %0d: got %b expected %b", i, obs, e);
         end
      end
   endtask

   task automatic test_change_mid();
      logic [9:0] e;
      bit found = 0;
      div_ratio = 8'd4;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL chg_wait: got %b expected %b", obs, e);
         end
         @(negedge ref_clk); #1;
         if (q.size() > 0 && q[0].ratio == 4 && cur_pos() == 1) found = 1;
      end
      n_chk++;
      if (!found) begin
         n_fail++;
         $display("FAIL chg_sync: got no ratio-4 counter==1, expected one");
      end
      div_ratio = 8'd6;
      for (int i = 0; i < 16; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL chg_hi cyc %0d: got %b expected %b", i, obs, e);
         end
         @(negedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL chg_lo cyc %0d: got %b expected %b", i, obs, e);
         end
      end
   endtask

   task automatic test_disable_mid();
      logic [9:0] e;
      bit found = 0;
      div_ratio = 8'd4;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL dis_wait: got %b expected %b", obs, e);
         end
         @(negedge ref_clk); #1;
         if (q.size() > 0 && q[0].ratio == 4 && cur_pos() == 1) found = 1;
      end
      n_chk++;
      if (!found) begin
         n_fail++;
         $display("FAIL dis_sync: got no ratio-4 counter==1, expected one");
      end
      clk_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL dis_hi cyc %0d: got %b expected %b", i, obs, e);
         end
         @(negedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL dis_lo cyc %0d: got %b expected %b", i, obs, e);
         end
      end
   endtask

   task automatic test_bypass_ratios();
      logic [9:0] e;
      int ticks = 0;
      clk_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         div_ratio = (i < 6) ? 8'd1 : 8'd0;
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL byp_hi r=%0d: got %b expected %b", div_ratio, obs, e);
         end
         ticks += int'(div_tick);
         @(negedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL byp_lo r=%0d: got %b expected %b", div_ratio, obs, e);
         end
      end
      n_chk++;
      if (ticks !== 0) begin
         n_fail++;
         $display("FAIL byp_ticks: got %0d expected 0", ticks);
      end
   endtask

   task automatic test_ratio255();
      logic [9:0] e;
      int his = 0;
      int ticks = 0;
      int exp_his;
`ifdef CLK_DIV_ODD_DUTY_EN
      exp_his = 127;
`else
      exp_his = 128;
`endif
      div_ratio = 8'd255;
      for (int i = 0; i < 255; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL r255_hi cyc %0d: got %b expected %b", i, obs, e);
         end
         his += int'(div_clk);
         ticks += int'(div_tick);
         @(negedge ref_clk); #1;
      end
      n_chk++;
      if (his !== exp_his || ticks !== 1) begin
         n_fail++;
         $display("FAIL r255_period: got high=%0d ticks=%0d expected %0d/1",
                  his, ticks, exp_his);
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] e;
      bit found = 0;
      div_ratio = 8'd6;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL rstm_wait: got %b expected %b", obs, e);
         end
         @(negedge ref_clk); #1;
         if (q.size() > 0 && q[0].ratio == 6 && cur_pos() == 2) found = 1;
      end
      n_chk++;
      if (!found) begin
         n_fail++;
         $display("FAIL rstm_sync: got no ratio-6 counter==2, expected one");
      end
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      n_chk++;
      if (obs !== 10'b0) begin
         n_fail++;
         $display("FAIL rstm_async: got %b expected %b", obs, 10'b0);
      end
      @(negedge ref_clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL rstm_hi cyc %0d: got %b expected %b", i, obs, e);
         end
         if (i == 0) begin
            n_chk++;
            if (div_tick !== 1'b1) begin
               n_fail++;
               $display("FAIL rstm_tick: got %b expected 1", div_tick);
            end
         end
         @(negedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL rstm_lo cyc %0d: got %b expected %b", i, obs, e);
         end
      end
   endtask

   task automatic test_random();
      logic [9:0] e;
      int r;
      for (int i = 0; i < 3000; i++) begin
         @(posedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL rand_hi cyc %0d: got %b expected %b", i, obs, e);
         end
         @(negedge ref_clk); #1;
         e = exp_now(); n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL rand_lo cyc %0d: got %b expected %b", i, obs, e);
         end
         if ($urandom_range(0, 3) == 0) begin
            clk_en = ($urandom_range(0, 5) != 0);
            r = int'($urandom_range(0, 15));
            div_ratio = (r == 15) ? 8'd255 : (r == 14) ? 8'd254 : 8'(r);
         end
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            q.delete();
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clk_en = 1'b0;
      div_ratio = 8'd0;
      test_reset();
      test_ratio4();
      test_ratio5();
      test_change_mid();
      test_disable_mid();
      test_bypass_ratios();
      test_ratio255();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
